// File: rtl/word_fetch_assembler.sv
// Fetches one aligned 32-bit word from a byte-wide memory as four MOV/MOC handshakes.
// It assembles the bytes and then pulses le_o so the downstream register captures word_o.
module word_fetch_assembler #(
  parameter int ADDR_WIDTH = 32,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mov_o,
  input  logic                  moc_i,
  input  logic [7:0]            mem_data_i,
  output logic [31:0]           word_o,
  output logic                  le_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'((MAX_WAIT > 0) ? (MAX_WAIT - 1) : 0);

  typedef enum logic [2:0] {IDLE, REQ, REL, DONE, ERR} state_t;

  state_t                  state_q;
  logic [1:0]              cnt_q;
  logic [WW-1:0]           wait_q;
  logic [31:0]             asm_q;
  logic [31:0]             asm_d;
  logic [31:0]             word_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic                    mov_q;
  logic                    le_q;
  logic                    busy_q;
  logic                    err_q;
  logic [1:0]              lane;
  logic                    timeout;

  // Big-endian puts the first byte fetched in the top lane (3 - cnt == ~cnt).
  assign lane    = BIG_ENDIAN ? ~cnt_q : cnt_q;
  assign timeout = (MAX_WAIT != 0) && (wait_q == WAIT_LAST);

  always_comb begin
    asm_d = asm_q;
    asm_d[{lane, 3'b000} +: 8] = mem_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wait_q     <= '0;
      asm_q      <= '0;
      word_q     <= '0;
      mem_addr_q <= '0;
      mov_q      <= 1'b0;
      le_q       <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            if (addr_i[1:0] == 2'b00) begin
              mem_addr_q <= addr_i;
              cnt_q      <= '0;
              wait_q     <= '0;
              mov_q      <= 1'b1;
              state_q    <= REQ;
            end else begin
              err_q   <= 1'b1;
              state_q <= ERR;
            end
          end
        end
        REQ: begin
          if (moc_i) begin
            asm_q   <= asm_d;
            mov_q   <= 1'b0;
            wait_q  <= '0;
            state_q <= REL;
          end else if (timeout) begin
            mov_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= ERR;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        REL: begin
          if (!moc_i) begin
            if (cnt_q != 2'd3) begin
              cnt_q      <= cnt_q + 2'd1;
              mem_addr_q <= mem_addr_q + 1'b1;
              wait_q     <= '0;
              mov_q      <= 1'b1;
              state_q    <= REQ;
            end else begin
              word_q  <= asm_q;
              le_q    <= 1'b1;
              state_q <= DONE;
            end
          end else if (timeout) begin
            err_q   <= 1'b1;
            state_q <= ERR;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        DONE: begin
          le_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        ERR: begin
          err_q   <= 1'b0;
          mov_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr_o = mem_addr_q;
  assign mov_o      = mov_q;
  assign word_o     = word_q;
  assign le_o       = le_q;
  assign busy_o     = busy_q;
  assign err_o      = err_q;

endmodule
